// File: rtl/spmv_row_issuer_if.sv
// spmv_row_issuer_if: valid/ready stream bundle used for every issuer stream port
interface spmv_row_issuer_if #(parameter int DW = 64);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  modport master(output tdata, tvalid, input tready);
  modport slave(input tdata, tvalid, output tready);
endinterface

// File: rtl/spmv_row_issuer.sv
// spmv_row_issuer: turns CSR row pointers, values and columns into A/B/TIMES streams for the dot engine.
// Optional SPMV_ISSUE_SKIP_EMPTY_EN suppresses the TIMES beat of empty rows.
module spmv_row_issuer #(
  parameter int XADDR_W = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  spmv_row_issuer_if.slave     rowptr_s,
  input  logic                 S_AXIS_ROWPTR_tlast,
  spmv_row_issuer_if.slave     val_s,
  spmv_row_issuer_if.slave     col_s,
  spmv_row_issuer_if.master    a_m,
  spmv_row_issuer_if.master    b_m,
  spmv_row_issuer_if.master    times_m,
  output logic                 x_rd_en,
  output logic [XADDR_W-1:0]   x_rd_addr,
  input  logic [63:0]          x_rd_data,
  output logic                 err_ptr,
  output logic                 err_col,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, ROW, TIMES, ELEM} state_t;
  state_t      state_q, state_d;
  logic [31:0] prev_q, prev_d, len_q, len_d, rem_q, rem_d, len_new;
  logic        last_q, last_d, err_ptr_q, err_ptr_d, err_col_q, err_col_d;
  logic        s1_v_q, s1_v_d;
  logic [63:0] s1_val_q;
  logic [63:0] qa_q [2];
  logic [63:0] qb_q [2];
  logic [1:0]  cnt_q, cnt_d, occ, sa_q, sa_d, sb_q, sb_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic        ptr_fire, bad, fire_a, fire_b, retire, pop;
  assign rowptr_s.tready = rstn && (state_q == IDLE || state_q == ROW);
  assign ptr_fire = rowptr_s.tvalid && rowptr_s.tready;
  assign bad      = rowptr_s.tdata < prev_q;
  assign len_new  = bad ? 32'd0 : rowptr_s.tdata - prev_q;
  assign a_m.tvalid = cnt_q != 2'd0 && !sa_q[rd_q];
  assign b_m.tvalid = cnt_q != 2'd0 && !sb_q[rd_q];
  assign a_m.tdata  = qa_q[rd_q];
  assign b_m.tdata  = qb_q[rd_q];
  assign times_m.tvalid = state_q == TIMES;
  assign times_m.tdata  = len_q;
  assign fire_a = a_m.tvalid && a_m.tready;
  assign fire_b = b_m.tvalid && b_m.tready;
  // Head retires once both halves are out, freeing its slot in the same cycle
  assign retire = cnt_q != 2'd0 && (sa_q[rd_q] || fire_a) && (sb_q[rd_q] || fire_b);
  assign occ    = cnt_q + {1'b0, s1_v_q} - {1'b0, retire};
  assign pop    = rstn && state_q == ELEM && val_s.tvalid && col_s.tvalid && occ < 2'd2;
  assign val_s.tready = pop;
  assign col_s.tready = pop;
  assign x_rd_en   = pop;
  assign x_rd_addr = pop ? col_s.tdata[XADDR_W-1:0] : '0;
  assign err_ptr = err_ptr_q;
  assign err_col = err_col_q;
  assign busy    = state_q != IDLE || cnt_q != 2'd0 || s1_v_q;
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    len_d     = len_q;
    rem_d     = rem_q;
    last_d    = last_q;
    err_ptr_d = err_ptr_q;
    case (state_q)
      IDLE: if (ptr_fire) begin
        prev_d  = rowptr_s.tdata;
        state_d = S_AXIS_ROWPTR_tlast ? IDLE : ROW;
      end
      ROW: if (ptr_fire) begin
        prev_d    = rowptr_s.tdata;
        len_d     = len_new;
        last_d    = S_AXIS_ROWPTR_tlast;
        err_ptr_d = err_ptr_q | bad;
`ifdef SPMV_ISSUE_SKIP_EMPTY_EN
        state_d   = len_new != 32'd0 ? TIMES : S_AXIS_ROWPTR_tlast ? IDLE : ROW;
`else
        state_d   = TIMES;
`endif
      end
      TIMES: if (times_m.tready) begin
        rem_d   = len_q;
        state_d = len_q != 32'd0 ? ELEM : last_q ? IDLE : ROW;
      end
      default: if (pop) begin
        rem_d   = rem_q - 32'd1;
        state_d = rem_q != 32'd1 ? ELEM : last_q ? IDLE : ROW;
      end
    endcase
  end
  always_comb begin
    cnt_d     = occ;
    rd_d      = rd_q ^ retire;
    wr_d      = wr_q ^ s1_v_q;
    s1_v_d    = pop;
    err_col_d = err_col_q | (pop && |col_s.tdata[31:XADDR_W]);
    sa_d      = sa_q;
    sb_d      = sb_q;
    if (fire_a) sa_d[rd_q] = 1'b1;
    if (fire_b) sb_d[rd_q] = 1'b1;
    if (s1_v_q) sa_d[wr_q] = 1'b0;
    if (s1_v_q) sb_d[wr_q] = 1'b0;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      len_q     <= '0;
      rem_q     <= '0;
      last_q    <= 1'b0;
      err_ptr_q <= 1'b0;
      err_col_q <= 1'b0;
      s1_v_q    <= 1'b0;
      cnt_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      sa_q      <= '0;
      sb_q      <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      len_q     <= len_d;
      rem_q     <= rem_d;
      last_q    <= last_d;
      err_ptr_q <= err_ptr_d;
      err_col_q <= err_col_d;
      s1_v_q    <= s1_v_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
    end
  end
  always_ff @(posedge clk) begin
    if (pop) s1_val_q <= val_s.tdata;
    if (s1_v_q) begin
      qa_q[wr_q] <= s1_val_q;
      qb_q[wr_q] <= x_rd_data;
    end
  end
endmodule

// File: tb/tb_spmv_row_issuer.sv
// tb_spmv_row_issuer: directed stream scenarios for spmv_row_issuer with stream drivers, x buffer model and scoreboards.
module tb_spmv_row_issuer;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;
  spmv_row_issuer_if #(.DW(32)) rp_if ();
  spmv_row_issuer_if #(.DW(64)) val_if ();
  spmv_row_issuer_if #(.DW(32)) col_if ();
  spmv_row_issuer_if #(.DW(64)) a_if ();
  spmv_row_issuer_if #(.DW(64)) b_if ();
  spmv_row_issuer_if #(.DW(32)) t_if ();
  logic        rp_tlast, x_rd_en, err_ptr, err_col, busy;
  logic [15:0] x_rd_addr, last_addr;
  logic [63:0] x_rd_data;
  spmv_row_issuer #(.XADDR_W(16)) dut (
    .clk(clk), .rstn(rstn), .rowptr_s(rp_if), .S_AXIS_ROWPTR_tlast(rp_tlast),
    .val_s(val_if), .col_s(col_if), .a_m(a_if), .b_m(b_if), .times_m(t_if),
    .x_rd_en(x_rd_en), .x_rd_addr(x_rd_addr), .x_rd_data(x_rd_data),
    .err_ptr(err_ptr), .err_col(err_col), .busy(busy)
  );
  always @(posedge clk) if (x_rd_en) x_rd_data <= $realtobits(real'(x_rd_addr) + 0.5);
  int vectors = 0, errs = 0;
  int np = 0, na = 0, nb = 0, max_infl = 0, stab_bad = 0, busy_bad = 0;
  bit rnd = 0;
  logic sa = 0, sb = 0, st = 0;
  logic [63:0] ha, hb;
  logic [31:0] ht;
  logic [32:0] ptr_fifo [$];
  logic [63:0] val_fifo [$];
  logic [31:0] col_fifo [$];
  logic [63:0] got_a [$];
  logic [63:0] got_b [$];
  logic [31:0] got_t [$];
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // One clock: sample handshakes at negedge, advance stream drivers just after posedge
  task automatic tick();
    logic fp, fv;
    int infl;
    @(negedge clk);
    fp = rp_if.tvalid && rp_if.tready;
    fv = val_if.tvalid && val_if.tready;
    if (!rstn) begin
      np = 0; na = 0; nb = 0; sa = 0; sb = 0; st = 0;
    end else begin
      if (sa && (!a_if.tvalid || a_if.tdata !== ha)) stab_bad++;
      if (sb && (!b_if.tvalid || b_if.tdata !== hb)) stab_bad++;
      if (st && (!t_if.tvalid || t_if.tdata !== ht)) stab_bad++;
      sa = a_if.tvalid && !a_if.tready; ha = a_if.tdata;
      sb = b_if.tvalid && !b_if.tready; hb = b_if.tdata;
      st = t_if.tvalid && !t_if.tready; ht = t_if.tdata;
      if (a_if.tvalid && a_if.tready) begin got_a.push_back(a_if.tdata); na++; if (!busy) busy_bad++; end
      if (b_if.tvalid && b_if.tready) begin got_b.push_back(b_if.tdata); nb++; if (!busy) busy_bad++; end
      if (t_if.tvalid && t_if.tready) got_t.push_back(t_if.tdata);
      if (fv) np++;
      infl = np - (na < nb ? na : nb);
      if (infl > max_infl) max_infl = infl;
      if (x_rd_en) last_addr = x_rd_addr;
    end
    @(posedge clk);
    #1;
    if (fp && ptr_fifo.size() > 0) void'(ptr_fifo.pop_front());
    if (fv && val_fifo.size() > 0) void'(val_fifo.pop_front());
    if (fv && col_fifo.size() > 0) void'(col_fifo.pop_front());
    rp_if.tvalid  = ptr_fifo.size() > 0;
    rp_if.tdata   = ptr_fifo.size() > 0 ? ptr_fifo[0][31:0] : 32'd0;
    rp_tlast      = ptr_fifo.size() > 0 ? ptr_fifo[0][32] : 1'b0;
    val_if.tvalid = val_fifo.size() > 0;
    val_if.tdata  = val_fifo.size() > 0 ? val_fifo[0] : 64'd0;
    col_if.tvalid = col_fifo.size() > 0;
    col_if.tdata  = col_fifo.size() > 0 ? col_fifo[0] : 32'd0;
    a_if.tready   = rnd ? ($urandom_range(0, 99) < 50) : 1'b1;
    b_if.tready   = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
    t_if.tready   = 1'b1;
  endtask
  task automatic drain(string tag);
    int n = 0;
    while (n < 2000 && (ptr_fifo.size() != 0 || val_fifo.size() != 0 || busy)) begin
      tick();
      n++;
    end
    chk({tag, "_finished"}, 64'(n < 2000), 64'd1);
    repeat (3) tick();
  endtask
  task automatic cmp(string tag, input logic [63:0] ea[$], input logic [63:0] eb[$], input logic [31:0] et[$]);
    chk({tag, "_a_count"}, 64'(got_a.size()), 64'(ea.size()));
    chk({tag, "_b_count"}, 64'(got_b.size()), 64'(eb.size()));
    chk({tag, "_times_count"}, 64'(got_t.size()), 64'(et.size()));
    foreach (ea[i]) if (i < got_a.size()) chk($sformatf("%s_a%0d", tag, i), got_a[i], ea[i]);
    foreach (eb[i]) if (i < got_b.size()) chk($sformatf("%s_b%0d", tag, i), got_b[i], eb[i]);
    foreach (et[i]) if (i < got_t.size()) chk($sformatf("%s_times%0d", tag, i), 64'(got_t[i]), 64'(et[i]));
    got_a.delete(); got_b.delete(); got_t.delete();
  endtask
  initial begin
    logic [63:0] ea [$];
    logic [63:0] eb [$];
    logic [31:0] et [$];
    int n;
    rstn = 1'b0;
    rp_if.tvalid = 0; rp_if.tdata = 0; rp_tlast = 0;
    val_if.tvalid = 0; val_if.tdata = 0; col_if.tvalid = 0; col_if.tdata = 0;
    a_if.tready = 1; b_if.tready = 1; t_if.tready = 1;
    tick(); tick();
    chk("rst_a_tvalid", 64'(a_if.tvalid), 64'd0);
    chk("rst_b_tvalid", 64'(b_if.tvalid), 64'd0);
    chk("rst_times_tvalid", 64'(t_if.tvalid), 64'd0);
    chk("rst_ptr_tready", 64'(rp_if.tready), 64'd0);
    chk("rst_val_tready", 64'(val_if.tready), 64'd0);
    chk("rst_col_tready", 64'(col_if.tready), 64'd0);
    chk("rst_x_rd_en", 64'(x_rd_en), 64'd0);
    chk("rst_x_rd_addr", 64'(x_rd_addr), 64'd0);
    chk("rst_err_ptr", 64'(err_ptr), 64'd0);
    chk("rst_err_col", 64'(err_col), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rstn = 1'b1;
    // Basic matrix, all sinks ready
    ptr_fifo = '{33'h0_0000_0000, 33'h0_0000_0003, 33'h1_0000_0005};
    val_fifo = '{64'hC0DE_0000_0000_0000, 64'hC0DE_0000_0000_0001, 64'hC0DE_0000_0000_0002,
                 64'hC0DE_0000_0000_0003, 64'hC0DE_0000_0000_0004};
    col_fifo = '{32'd1, 32'd4, 32'd2, 32'd0, 32'd7};
    drain("basic");
    ea = '{64'hC0DE_0000_0000_0000, 64'hC0DE_0000_0000_0001, 64'hC0DE_0000_0000_0002,
           64'hC0DE_0000_0000_0003, 64'hC0DE_0000_0000_0004};
    eb = '{64'h3FF8_0000_0000_0000, 64'h4012_0000_0000_0000, 64'h4004_0000_0000_0000,
           64'h3FE0_0000_0000_0000, 64'h401E_0000_0000_0000};
    et = '{32'd3, 32'd2};
    cmp("basic", ea, eb, et);
    chk("basic_busy_order", 64'(busy_bad), 64'd0);
    // Same matrix with random backpressure on A and B
    rnd = 1;
    ptr_fifo = '{33'h0_0000_0000, 33'h0_0000_0003, 33'h1_0000_0005};
    val_fifo = ea;
    col_fifo = '{32'd1, 32'd4, 32'd2, 32'd0, 32'd7};
    drain("stall");
    rnd = 0;
    cmp("stall", ea, eb, et);
    chk("stall_max_inflight_le2", 64'(max_infl <= 2), 64'd1);
    chk("stall_hold_stable", 64'(stab_bad), 64'd0);
    chk("stall_busy_order", 64'(busy_bad), 64'd0);
    // Empty middle row
    ptr_fifo = '{33'h0_0000_0000, 33'h0_0000_0002, 33'h0_0000_0002, 33'h1_0000_0004};
    val_fifo = '{64'hBEEF_0000_0000_0010, 64'hBEEF_0000_0000_0011, 64'hBEEF_0000_0000_0012, 64'hBEEF_0000_0000_0013};
    col_fifo = '{32'd0, 32'd1, 32'd2, 32'd3};
    drain("empty");
    ea = '{64'hBEEF_0000_0000_0010, 64'hBEEF_0000_0000_0011, 64'hBEEF_0000_0000_0012, 64'hBEEF_0000_0000_0013};
    eb = '{64'h3FE0_0000_0000_0000, 64'h3FF8_0000_0000_0000, 64'h4004_0000_0000_0000, 64'h400C_0000_0000_0000};
`ifdef SPMV_ISSUE_SKIP_EMPTY_EN
    et = '{32'd2, 32'd2};
`else
    et = '{32'd2, 32'd0, 32'd2};
`endif
    cmp("empty", ea, eb, et);
    chk("empty_err_ptr_clear", 64'(err_ptr), 64'd0);
    // Decreasing pointer
    ptr_fifo = '{33'h0_0000_0005, 33'h1_0000_0003};
    drain("decr");
    ea = {};
    eb = {};
`ifdef SPMV_ISSUE_SKIP_EMPTY_EN
    et = {};
`else
    et = '{32'd0};
`endif
    cmp("decr", ea, eb, et);
    chk("decr_err_ptr", 64'(err_ptr), 64'd1);
    // Out-of-range column
    ptr_fifo = '{33'h0_0000_0000, 33'h1_0000_0001};
    val_fifo = '{64'h1234_5678_9ABC_DEF0};
    col_fifo = '{32'h0001_0005};
    drain("col");
    ea = '{64'h1234_5678_9ABC_DEF0};
    eb = '{64'h4016_0000_0000_0000};
    et = '{32'd1};
    cmp("col", ea, eb, et);
    chk("col_err_col", 64'(err_col), 64'd1);
    chk("col_x_rd_addr", 64'(last_addr), 64'h5);
    chk("col_err_ptr_sticky", 64'(err_ptr), 64'd1);
    // Reset in the middle of a row
    ptr_fifo = '{33'h0_0000_0000, 33'h1_0000_0003};
    val_fifo = '{64'hAAAA_0000_0000_0001, 64'hAAAA_0000_0000_0002, 64'hAAAA_0000_0000_0003};
    col_fifo = '{32'd6, 32'd1, 32'd2};
    n = 0;
    while (n < 200 && got_a.size() < 2) begin
      tick();
      n++;
    end
    chk("rmr_two_sent", 64'(got_a.size()), 64'd2);
    rstn = 1'b0;
    ptr_fifo.delete(); val_fifo.delete(); col_fifo.delete();
    rp_if.tvalid = 0; val_if.tvalid = 0; col_if.tvalid = 0;
    tick();
    chk("rmr_a_tvalid", 64'(a_if.tvalid), 64'd0);
    chk("rmr_b_tvalid", 64'(b_if.tvalid), 64'd0);
    chk("rmr_times_tvalid", 64'(t_if.tvalid), 64'd0);
    chk("rmr_busy", 64'(busy), 64'd0);
    chk("rmr_err_ptr_cleared", 64'(err_ptr), 64'd0);
    chk("rmr_err_col_cleared", 64'(err_col), 64'd0);
    tick();
    rstn = 1'b1;
    repeat (5) tick();
    ea = '{64'hAAAA_0000_0000_0001, 64'hAAAA_0000_0000_0002};
    eb = '{64'h401A_0000_0000_0000, 64'h3FF8_0000_0000_0000};
    et = '{32'd3};
    cmp("rmr_partial", ea, eb, et);
    ptr_fifo = '{33'h0_0000_0000, 33'h1_0000_0001};
    val_fifo = '{64'h5555_0000_0000_0007};
    col_fifo = '{32'd2};
    drain("after_rst");
    ea = '{64'h5555_0000_0000_0007};
    eb = '{64'h4004_0000_0000_0000};
    et = '{32'd1};
    cmp("after_rst", ea, eb, et);
    chk("final_hold_stable", 64'(stab_bad), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
